// File: rtl/hash_feeder_pkg.sv
// rtl/hash_feeder_pkg.sv - shared types and constants for the hash message feeder
package hash_feeder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_EOF,
    ST_WAIT_H
  } feeder_state_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hash_byte_fifo.sv
// rtl/hash_byte_fifo.sv - synchronous byte FIFO with registered storage and no bypass
module hash_byte_fifo
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [BYTE_W-1:0]   din,
  output logic [BYTE_W-1:0]   dout,
  output logic                full,
  output logic                empty,
  output logic [ptr_w(DEPTH):0] count
);

  localparam int PW = ptr_w(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hash_msg_feeder.sv
// rtl/hash_msg_feeder.sv - frames a host byte stream into F_dr/F_rtr transfers for the hash core
module hash_msg_feeder
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              msg_empty,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              core_start,
  output logic [BYTE_W-1:0] M,
  output logic              F_dr,
  input  logic              F_rtr,
  output logic              End_of_File,
  output logic              empty_msg_flag,
  input  logic              H_ready,
  output logic              busy,
  output logic [LEN_W-1:0]  byte_count
);

  localparam int CW = ptr_w(DEPTH) + 1;

  feeder_state_t     state_q, state_d;
  logic              core_start_q, core_start_d;
  logic              eof_q, eof_d;
  logic              empty_flag_q, empty_flag_d;
  logic [LEN_W-1:0]  byte_count_q, byte_count_d;

  logic              fifo_clear, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [BYTE_W-1:0] fifo_dout;
  logic              core_side;

  hash_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign core_side      = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign in_ready       = (state_q == ST_FILL) && !fifo_full;
  assign F_dr           = core_side && !fifo_empty;
  assign M              = F_dr ? fifo_dout : '0;
  assign fifo_push      = in_valid && in_ready;
  assign fifo_pop       = F_dr && F_rtr;
  assign busy           = (state_q != ST_IDLE);
  assign core_start     = core_start_q;
  assign End_of_File    = eof_q;
  assign empty_msg_flag = empty_flag_q;
  assign byte_count     = byte_count_q;

  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    // End_of_File trails the EOF state by one cycle so it always follows core_start.
    eof_d        = (state_q == ST_EOF);
    empty_flag_d = empty_flag_q;
    byte_count_d = byte_count_q;
    fifo_clear   = 1'b0;

    if (fifo_pop && (byte_count_q != '1)) begin
      byte_count_d = byte_count_q + LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_start_d = 1'b1;
          fifo_clear   = 1'b1;
          byte_count_d = '0;
          empty_flag_d = msg_empty;
          state_d      = msg_empty ? ST_EOF : ST_FILL;
        end
      end
      ST_FILL: begin
        if (fifo_push && in_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop)) begin
          state_d = ST_EOF;
        end
      end
      ST_EOF: begin
        state_d = ST_WAIT_H;
      end
      ST_WAIT_H: begin
        if (H_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      core_start_q <= 1'b0;
      eof_q        <= 1'b0;
      empty_flag_q <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      eof_q        <= eof_d;
      empty_flag_q <= empty_flag_d;
      byte_count_q <= byte_count_d;
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb/tb_hash_msg_feeder.sv - self-checking bench for hash_msg_feeder
module tb_hash_msg_feeder;

  localparam int DEPTH = 4;
  localparam int LEN_W = 32;
  localparam int P_IDLE = 0, P_FILL = 1, P_DRAIN = 2, P_EOF = 3, P_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, msg_empty = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic F_rtr = 1'b0, H_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, core_start, F_dr, End_of_File, empty_msg_flag, busy;
  logic [7:0] M;
  logic [LEN_W-1:0] byte_count;

  hash_msg_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_empty(msg_empty),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .core_start(core_start), .M(M), .F_dr(F_dr), .F_rtr(F_rtr),
    .End_of_File(End_of_File), .empty_msg_flag(empty_msg_flag), .H_ready(H_ready),
    .busy(busy), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;

  logic [7:0] m_q[$];
  int m_phase = P_IDLE;
  logic [LEN_W-1:0] m_cnt = '0;
  bit m_flag = 0, m_cs = 0, m_eof = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int cs_count = 0, eof_count = 0, fdr_count = 0, cs_cyc = 0, eof_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue-based reference: bytes enter at the back, the core sees the front.
  task automatic model_step();
    bit push, pop;
    if (rst) begin
      m_q.delete();
      m_phase = P_IDLE;
      m_cnt = '0;
      m_flag = 0;
      m_cs = 0;
      m_eof = 0;
    end else begin
      push = (m_phase == P_FILL) && (m_q.size() < DEPTH) && in_valid;
      pop  = ((m_phase == P_FILL) || (m_phase == P_DRAIN)) && (m_q.size() > 0) && F_rtr;
      m_cs  = (m_phase == P_IDLE) && start;
      m_eof = (m_phase == P_EOF);
      if (pop) begin
        void'(m_q.pop_front());
        if (m_cnt != '1) m_cnt = m_cnt + 1;
      end
      if (push) m_q.push_back(in_data);
      case (m_phase)
        P_IDLE:  if (start) begin
                   m_q.delete();
                   m_cnt = '0;
                   m_flag = msg_empty;
                   m_phase = msg_empty ? P_EOF : P_FILL;
                 end
        P_FILL:  if (push && in_last) m_phase = P_DRAIN;
        P_DRAIN: if (m_q.size() == 0) m_phase = P_EOF;
        P_EOF:   m_phase = P_WAIT;
        default: if (H_ready) m_phase = P_IDLE;
      endcase
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
  end

  always @(negedge clk) begin
    if (armed) begin
      bit e_fdr;
      e_fdr = ((m_phase == P_FILL) || (m_phase == P_DRAIN)) && (m_q.size() > 0);
      chk("in_ready", in_ready, (m_phase == P_FILL) && (m_q.size() < DEPTH));
      chk("core_start", core_start, m_cs);
      chk("F_dr", F_dr, e_fdr);
      chk("End_of_File", End_of_File, m_eof);
      chk("empty_msg_flag", empty_msg_flag, m_flag);
      chk("busy", busy, m_phase != P_IDLE);
      chk("byte_count", byte_count, m_cnt);
      if (e_fdr) chk("M", M, m_q[0]);
      if (F_dr === 1'b1) fdr_count++;
      if ((F_dr === 1'b1) && F_rtr) got.push_back(M);
      if (core_start === 1'b1) begin cs_count++; cs_cyc = cyc; end
      if (End_of_File === 1'b1) begin eof_count++; eof_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit e);
    start = 1'b1;
    msg_empty = e;
    tick();
    start = 1'b0;
    msg_empty = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready stayed 0 for byte %0h, required 1", d);
    end
  endtask

  task automatic wait_eof(input int max);
    bit seen;
    seen = 0;
    for (int t = 0; t < max && !seen; t++) begin
      @(negedge clk);
      seen = (End_of_File === 1'b1);
    end
    chk("eof_seen", seen, 1);
    tick();
  endtask

  task automatic finish_msg();
    H_ready = 1'b1;
    tick();
    H_ready = 1'b0;
  endtask

  task automatic check_got(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(name, got[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    got.delete();
    cs_count = 0;
    eof_count = 0;
    fdr_count = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    armed = 1;
    tick();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_F_dr", F_dr, 0);
    chk("rst_eof", End_of_File, 0);
    chk("rst_flag", empty_msg_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_M", M, 0);
    tick();
    rst = 1'b0;

    // Normal three-byte message.
    clear_logs();
    F_rtr = 1'b1;
    pulse_start(0);
    send_byte(8'h41, 0);
    send_byte(8'h42, 0);
    send_byte(8'h43, 1);
    wait_eof(20);
    exp_q = {8'h41, 8'h42, 8'h43};
    check_got("normal_M");
    chk("normal_count", byte_count, 3);
    chk("normal_busy", busy, 1);
    chk("normal_cs", cs_count, 1);
    chk("normal_eof_cnt", eof_count, 1);
    finish_msg();
    @(negedge clk);
    chk("normal_idle", busy, 0);
    tick();

    // Empty message.
    clear_logs();
    pulse_start(1);
    wait_eof(10);
    chk("empty_eof_delay", eof_cyc - cs_cyc, 1);
    chk("empty_fdr", fdr_count, 0);
    chk("empty_flag", empty_msg_flag, 1);
    chk("empty_count", byte_count, 0);
    finish_msg();
    @(negedge clk);
    chk("empty_flag_held", empty_msg_flag, 1);
    tick();

    // Backpressure with six bytes into a four-entry FIFO.
    clear_logs();
    F_rtr = 1'b0;
    pulse_start(0);
    fork
      begin
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), i == 5);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_fdr", F_dr, 1);
        chk("bp_head", M, 8'hA0);
        chk("bp_flag_cleared", empty_msg_flag, 0);
        tick();
        F_rtr = 1'b1;
      end
    join
    wait_eof(30);
    exp_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    check_got("bp_M");
    chk("bp_count", byte_count, 6);
    finish_msg();

    // Steady push+pop at occupancy two, wrapping the pointers.
    clear_logs();
    F_rtr = 1'b0;
    pulse_start(0);
    send_byte(8'h10, 0);
    send_byte(8'h11, 0);
    F_rtr = 1'b1;
    for (int i = 2; i < 10; i++) send_byte(8'h10 + 8'(i), i == 9);
    wait_eof(20);
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    check_got("wrap_M");
    chk("wrap_count", byte_count, 10);
    finish_msg();

    // Starts outside IDLE are ignored.
    clear_logs();
    F_rtr = 1'b1;
    pulse_start(0);
    send_byte(8'h55, 0);
    pulse_start(0);
    send_byte(8'h56, 1);
    wait_eof(20);
    pulse_start(1);
    chk("ign_cs", cs_count, 1);
    chk("ign_count", byte_count, 2);
    chk("ign_flag", empty_msg_flag, 0);
    chk("ign_busy", busy, 1);
    finish_msg();

    // Reset while draining two buffered bytes.
    clear_logs();
    F_rtr = 1'b0;
    pulse_start(0);
    send_byte(8'h71, 0);
    send_byte(8'h72, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_F_dr", F_dr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_count", byte_count, 0);
    chk("mid_M", M, 0);
    chk("mid_eof", End_of_File, 0);
    tick();
    clear_logs();
    F_rtr = 1'b1;
    pulse_start(0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 1);
    wait_eof(20);
    exp_q = {8'h01, 8'h02};
    check_got("post_rst_M");
    chk("post_rst_count", byte_count, 2);
    chk("post_rst_cs", cs_count, 1);
    finish_msg();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
Upstream message-framing stage for the hash core. It accepts a byte stream from the host over a valid/ready interface and buffers it in a small FIFO. It presents the bytes to the core's control part one at a time using the F_dr / F_rtr handshake, then raises End_of_File once the final byte has been consumed. It also produces the core start pulse, flags empty messages and counts message length.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
LEN_W, 32, width of the consumed-byte counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  host request to begin a new message; sampled only in IDLE
msg_empty  in  1  qualifies start: the message has zero bytes
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_last  in  1  qualifies in_valid: this is the final byte
in_ready  out  1  feeder can accept a host byte this cycle
core_start  out  1  one-cycle start pulse to the hash core
M  out  8  byte presented to the core (the FIFO head)
F_dr  out  1  M is valid
F_rtr  in  1  core ready to receive
End_of_File  out  1  end-of-message strobe to the core
empty_msg_flag  out  1  current message has zero bytes
H_ready  in  1  core reports the hash is complete
busy  out  1  state is not IDLE
byte_count  out  LEN_W  bytes consumed by the core for the current message

Behaviour:
- Reset (rst=1 at a clk edge, valid in any state including mid-message):
  - state = IDLE; FIFO pointers and occupancy = 0.
  - All outputs 0: in_ready, core_start, F_dr, End_of_File, empty_msg_flag, busy, byte_count, M.
- FSM states: IDLE, FILL, DRAIN, EOF, WAIT_H.
- IDLE:
  - start=1, msg_empty=0: clear FIFO and byte_count, go to FILL.
  - start=1, msg_empty=1: set empty_msg_flag, go to EOF.
  - Either case: core_start=1 in the cycle after start is sampled, for exactly 1 cycle.
  - start is ignored in every state other than IDLE.
- FILL:
  - in_ready = !fifo_full, combinational from the registered occupancy.
  - A push occurs when in_valid & in_ready.
  - A push with in_last=1 moves to DRAIN in the next cycle.
  - When full, no push is accepted even if a pop happens in the same cycle.
- Core side (FILL and DRAIN only):
  - F_dr = !fifo_empty; M = FIFO head.
  - A pop occurs when F_dr & F_rtr.
  - Each pop increments byte_count; byte_count saturates at all-ones.
  - Simultaneous push and pop leaves occupancy unchanged.
  - M is undefined while F_dr=0 and must not be checked then.
- DRAIN:
  - in_ready=0.
  - When occupancy reaches 0 (including via the pop in the current cycle), go to EOF.
- EOF:
  - End_of_File=1 for exactly one cycle, with F_dr=0.
  - Then go to WAIT_H.
- WAIT_H:
  - Hold byte_count and empty_msg_flag.
  - H_ready=1 moves to IDLE.
  - empty_msg_flag clears on the next accepted start, not on IDLE entry.
- busy = (state != IDLE).
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits, so full and empty are distinguished.
- Latency: a byte pushed into an empty FIFO is visible on F_dr/M on the next cycle (registered storage, no bypass).
- Protocol violations:
  - in_valid while not in FILL is dropped, since in_ready=0.
  - F_rtr is ignored while F_dr=0.

Decomposition:
- Package hash_feeder_pkg:
  - state enum type feeder_state_t.
  - BYTE_W=8 constant.
  - Helper function for the clog2-based pointer width.
- One sub-module, hash_byte_fifo: parameterised DEPTH synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, count, clear.
  - Same clk/rst.
- The top level holds the FSM, byte_count and the strobes.

Test Plan:
- Normal message:
  - Stimulus: reset; start(msg_empty=0); push 0x41,0x42,0x43 (last on 0x43); F_rtr held 1.
  - Response: core_start pulse; M sequence 41,42,43; one-cycle End_of_File after the last pop; byte_count=3; busy until H_ready.
- Empty message:
  - Stimulus: start with msg_empty=1.
  - Response: core_start, then End_of_File one cycle later; F_dr never 1; empty_msg_flag=1; byte_count=0.
- Backpressure:
  - Stimulus: DEPTH=4, F_rtr=0, host pushes 6 bytes continuously.
  - Response: in_ready drops after the 4th byte; release F_rtr; all 6 bytes emerge in order; no loss or duplication.
- Simultaneous push/pop:
  - Stimulus: occupancy 2, push and pop in the same cycle.
  - Response: occupancy stays 2; FIFO wrap-around is exercised over 10 bytes with order preserved.
- Reset mid-message:
  - Stimulus: assert rst in DRAIN with 2 bytes buffered.
  - Response: next cycle all outputs 0, state IDLE; a new start behaves as after power-up.
- Ignored start:
  - Stimulus: start pulses during FILL and WAIT_H.
  - Response: no core_start; byte_count unaffected.
